// File: rtl/funnel_arb_pkg.sv
// funnel_arb_pkg: shared FSM state type and round-robin pointer increment for funnel_arbiter
package funnel_arb_pkg;
  typedef enum logic {IDLE, GRANTED} funnel_arb_state_e;
  function automatic int rr_next(input int ptr, input int n);
    return (ptr >= n - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/rr_priority_picker.sv
// rr_priority_picker: first set bit of req strictly after ptr, wrapping modulo NUM_REQ
module rr_priority_picker
  import funnel_arb_pkg::*;
#(
  parameter int NUM_REQ  = 4,
  parameter int ID_WIDTH = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0]  req,
  input  logic [ID_WIDTH-1:0] ptr,
  output logic                found,
  output logic [ID_WIDTH-1:0] idx
);
  logic [ID_WIDTH-1:0] c;
  always_comb begin
    found = 1'b0;
    idx   = '0;
    c     = ptr;
    for (int k = 0; k < NUM_REQ; k++) begin
      c = ID_WIDTH'(rr_next(int'(c), NUM_REQ));
      if (!found && req[c]) begin
        found = 1'b1;
        idx   = c;
      end
    end
  end
endmodule

// File: rtl/funnel_arbiter.sv
// funnel_arbiter: packet-granular round-robin arbiter feeding one registered AXI-stream output
module funnel_arbiter
  import funnel_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_mask,
  input  logic [NUM_REQ-1:0]            s_valid,
  output logic [NUM_REQ-1:0]            s_ready,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] s_data,
  input  logic [NUM_REQ-1:0]            s_last,
  output logic                          m_valid,
  input  logic                          m_ready,
  output logic [DATA_WIDTH-1:0]         m_data,
  output logic                          m_last,
  output logic [ID_WIDTH-1:0]           m_id,
  output logic                          busy
);
  funnel_arb_state_e   state;
  logic [ID_WIDTH-1:0] rr_ptr;
  logic [ID_WIDTH-1:0] grant_idx;
  logic [ID_WIDTH-1:0] pick;
  logic                found;
  logic                room;
  logic                accept;
  rr_priority_picker #(
    .NUM_REQ (NUM_REQ),
    .ID_WIDTH(ID_WIDTH)
  ) u_picker (
    .req  (s_valid & req_mask),
    .ptr  (rr_ptr),
    .found(found),
    .idx  (pick)
  );
  always_comb begin
    room    = !m_valid || m_ready;
    busy    = state == GRANTED;
    s_ready = (busy && room) ? NUM_REQ'(1) << grant_idx : '0;
    accept  = busy && room && s_valid[grant_idx];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      rr_ptr    <= ID_WIDTH'(NUM_REQ - 1);
      grant_idx <= '0;
      m_valid   <= 1'b0;
      m_data    <= '0;
      m_last    <= 1'b0;
      m_id      <= '0;
    end else begin
      if (state == IDLE && found) begin
        grant_idx <= pick;
        state     <= GRANTED;
      end
      if (accept) begin
        m_valid <= 1'b1;
        m_data  <= s_data[grant_idx*DATA_WIDTH +: DATA_WIDTH];
        m_last  <= s_last[grant_idx];
        m_id    <= grant_idx;
        if (s_last[grant_idx]) begin
          state  <= IDLE;
          rr_ptr <= grant_idx;
        end
      end else if (m_ready) begin
        m_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_funnel_arbiter.sv
// tb_funnel_arbiter: directed self-checking bench for funnel_arbiter
module tb_funnel_arbiter;
  localparam int N  = 4;
  localparam int DW = 64;
  localparam int IW = 2;
  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [N-1:0]  req_mask = '1;
  logic [N-1:0]  s_valid = '0;
  logic [N-1:0]  s_ready;
  logic [N*DW-1:0] s_data = '0;
  logic [N-1:0]  s_last = '0;
  logic          m_valid;
  logic          m_ready = 1'b1;
  logic [DW-1:0] m_data;
  logic          m_last;
  logic [IW-1:0] m_id;
  logic          busy;
  int errors = 0;
  int checks = 0;
  int beat[N];
  int plen[N];
  logic [DW-1:0] base[N];
  int ids[3];
  always #5 clk = ~clk;
  funnel_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .ID_WIDTH(IW)) dut (
    .clk(clk), .rst(rst), .req_mask(req_mask), .s_valid(s_valid), .s_ready(s_ready),
    .s_data(s_data), .s_last(s_last), .m_valid(m_valid), .m_ready(m_ready),
    .m_data(m_data), .m_last(m_last), .m_id(m_id), .busy(busy)
  );
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask
  task automatic drive();
    for (int i = 0; i < N; i++) begin
      s_data[i*DW +: DW] = base[i] + DW'(beat[i]);
      s_last[i] = beat[i] == plen[i] - 1;
    end
  endtask
  task automatic cyc();
    logic [N-1:0] acc;
    drive();
    #1;
    acc = s_valid & s_ready;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++)
      if (acc[i]) beat[i] = (beat[i] == plen[i] - 1) ? 0 : beat[i] + 1;
    drive();
  endtask
  task automatic do_reset();
    rst = 1'b1;
    s_valid = '0;
    m_ready = 1'b1;
    req_mask = '1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("rst_m_valid", 64'(m_valid), 64'd0);
    chk("rst_s_ready", 64'(s_ready), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_m_data", m_data, 64'd0);
    chk("rst_m_last", 64'(m_last), 64'd0);
    chk("rst_m_id", 64'(m_id), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) beat[i] = 0;
    drive();
  endtask
  initial begin
    int ph, p, id;
    for (int i = 0; i < N; i++) begin
      beat[i] = 0;
      plen[i] = 2;
      base[i] = DW'(i * 16);
    end
    do_reset();
    for (int k = 0; k < 10; k++) begin
      cyc();
      chk("idle_m_valid", 64'(m_valid), 64'd0);
      chk("idle_s_ready", 64'(s_ready), 64'd0);
      chk("idle_busy", 64'(busy), 64'd0);
    end
    s_valid = '1;
    for (int k = 1; k <= 18; k++) begin
      cyc();
      ph = k % 3;
      chk("fair_m_valid", 64'(m_valid), 64'(ph != 1));
      if (ph != 1) begin
        id = (ph == 2) ? (k / 3) % 4 : (k / 3 - 1) % 4;
        chk("fair_m_id", 64'(m_id), 64'(id));
        chk("fair_m_last", 64'(m_last), 64'(ph == 0));
        chk("fair_m_data", m_data, base[id] + 64'(ph == 0));
      end
    end
    do_reset();
    plen[2] = 3;
    base[2] = 64'hA;
    drive();
    s_valid = 4'b0100;
    cyc();
    chk("bp_busy", 64'(busy), 64'd1);
    chk("bp_s_ready0", 64'(s_ready), 64'b0100);
    cyc();
    chk("bp_a_valid", 64'(m_valid), 64'd1);
    chk("bp_a_data", m_data, 64'hA);
    chk("bp_a_id", 64'(m_id), 64'd2);
    m_ready = 1'b1;
    cyc();
    chk("bp_b_data", m_data, 64'hB);
    chk("bp_b_id", 64'(m_id), 64'd2);
    m_ready = 1'b0;
    #1;
    chk("bp_s_ready_stall", 64'(s_ready), 64'd0);
    cyc();
    chk("bp_hold1_valid", 64'(m_valid), 64'd1);
    chk("bp_hold1_data", m_data, 64'hB);
    cyc();
    chk("bp_hold2_data", m_data, 64'hB);
    chk("bp_hold2_last", 64'(m_last), 64'd0);
    m_ready = 1'b1;
    cyc();
    chk("bp_c_data", m_data, 64'hC);
    chk("bp_c_last", 64'(m_last), 64'd1);
    chk("bp_c_id", 64'(m_id), 64'd2);
    s_valid = '0;
    cyc();
    chk("bp_drain", 64'(m_valid), 64'd0);
    plen[2] = 2;
    base[2] = 64'd32;
    do_reset();
    req_mask = 4'b1010;
    s_valid = '1;
    ids[0] = 1;
    ids[1] = 3;
    ids[2] = 1;
    for (int k = 1; k <= 9; k++) begin
      cyc();
      ph = k % 3;
      chk("mask_m_valid", 64'(m_valid), 64'(ph != 1));
      if (ph != 1) begin
        p = (ph == 2) ? k / 3 : k / 3 - 1;
        chk("mask_m_id", 64'(m_id), 64'(ids[p]));
        chk("mask_m_last", 64'(m_last), 64'(ph == 0));
      end
      if (k == 8) req_mask = 4'b1000;
    end
    cyc();
    chk("mask_regrant_s_ready", 64'(s_ready), 64'b1000);
    chk("mask_regrant_m_valid", 64'(m_valid), 64'd0);
    cyc();
    chk("mask_after_id", 64'(m_id), 64'd3);
    chk("mask_after_valid", 64'(m_valid), 64'd1);
    plen[0] = 1;
    do_reset();
    s_valid = 4'b0001;
    for (int k = 1; k <= 6; k++) begin
      cyc();
      chk("single_m_valid", 64'(m_valid), 64'(k % 2 == 0));
      chk("single_busy", 64'(busy), 64'(k % 2 == 1));
      if (k % 2 == 0) begin
        chk("single_m_last", 64'(m_last), 64'd1);
        chk("single_m_id", 64'(m_id), 64'd0);
      end
    end
    plen[0] = 2;
    do_reset();
    plen[1] = 4;
    drive();
    req_mask = 4'b0010;
    s_valid = '1;
    cyc();
    chk("mid_grant_s_ready", 64'(s_ready), 64'b0010);
    cyc();
    chk("mid_beat0_valid", 64'(m_valid), 64'd1);
    chk("mid_beat0_data", m_data, 64'h10);
    rst = 1'b1;
    cyc();
    chk("mid_rst_m_valid", 64'(m_valid), 64'd0);
    chk("mid_rst_s_ready", 64'(s_ready), 64'd0);
    chk("mid_rst_busy", 64'(busy), 64'd0);
    rst = 1'b0;
    for (int i = 0; i < N; i++) beat[i] = 0;
    req_mask = '1;
    cyc();
    chk("post_rst_busy", 64'(busy), 64'd1);
    chk("post_rst_s_ready", 64'(s_ready), 64'b0001);
    cyc();
    chk("post_rst_valid", 64'(m_valid), 64'd1);
    chk("post_rst_id", 64'(m_id), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/funnel_arbiter.md
Name: funnel_arbiter

Overview:
- Packet-granular round-robin arbiter that shares one wide-to-narrow funnel between NUM_REQ AXI-stream requesters.
- Grants one requester at a time and holds the grant until that requester's beat with last=1 is accepted.
- Forwards beats through a single registered output stage.
- Sits directly upstream of the funnel; m_id travels with the data so downstream logic can demultiplex.

Parameters:
- NUM_REQ, 4, number of requesters (>=2).
- DATA_WIDTH, 64, beat width; equals the funnel input width.
- ID_WIDTH, $clog2(NUM_REQ), width of m_id.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high. One clock; reset is synchronous and active-high.
- req_mask  in  NUM_REQ  per-requester enable; 0 excludes that requester from new grants.
- s_valid  in  NUM_REQ  requester valid.
- s_ready  out  NUM_REQ  requester ready; one-hot or zero.
- s_data  in  NUM_REQ*DATA_WIDTH  requester data; requester i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- s_last  in  NUM_REQ  requester end-of-packet.
- m_valid  out  1  to funnel.
- m_ready  in  1  from funnel.
- m_data  out  DATA_WIDTH  to funnel.
- m_last  out  1  to funnel.
- m_id  out  ID_WIDTH  granted requester index for the beat on m_data.
- busy  out  1  high while the state is GRANTED.

Behaviour:
Reset values:
- state=IDLE, rr_ptr=NUM_REQ-1, grant_idx=0.
- m_valid=0, m_data=0, m_last=0, m_id=0, s_ready=0, busy=0.
- Reset mid-packet drops the output register contents and the grant immediately. No partial beat is emitted after reset.

State machine {IDLE, GRANTED}:
- IDLE:
  - eligible = s_valid & req_mask.
  - If eligible != 0, pick the first set bit scanning from rr_ptr+1 upward, wrapping modulo NUM_REQ.
  - grant_idx <= pick; state <= GRANTED.
  - s_ready is all 0 in IDLE, so there is one arbitration bubble per packet.
- GRANTED:
  - s_ready[grant_idx] = (!m_valid || m_ready). All other s_ready bits are 0.
  - Accept = s_valid[grant_idx] && s_ready[grant_idx].
  - On accept, the output register loads {data, last, grant_idx} and m_valid <= 1.
  - On accept with s_last=1: state <= IDLE and rr_ptr <= grant_idx.
  - req_mask is ignored while GRANTED; deasserting a mask bit never truncates an in-flight packet.

Output stage:
- If m_valid && m_ready and there is no accept in the same cycle, m_valid <= 0.
- A simultaneous drain and accept keeps m_valid=1 and loads the new beat (full throughput).
- m_data, m_last and m_id hold stable while m_valid && !m_ready (AXI-stream rule).
- Latency: 1 cycle from input accept to m_valid.

Boundary conditions:
- A requester whose s_valid drops mid-packet keeps the grant; the arbiter waits indefinitely.
- Single-beat packets (last on the first beat) are legal: IDLE, GRANTED, IDLE.
- With a single eligible requester it is re-granted back-to-back, costing 1 bubble cycle per packet.
- rr_ptr wraps from NUM_REQ-1 to 0.
- All requesters masked or idle: the arbiter stays in IDLE and m_valid drains normally.

Decomposition:
- Package funnel_arb_pkg holds:
  - typedef enum logic {IDLE, GRANTED} funnel_arb_state_e;
  - function rr_next(ptr) implementing the wrap-around increment.
- Sub-module rr_priority_picker (purely combinational):
  - Parameter NUM_REQ.
  - Inputs req[NUM_REQ] and ptr.
  - Outputs found and idx: the first set bit after ptr, with wrap.
- The top level holds the FSM, the rr_ptr/grant registers and the output register.

Test Plan:
- Reset then idle: all s_valid=0 for 10 cycles -> m_valid=0, s_ready=0, busy=0 throughout.
- Fairness: all 4 requesters continuously send 2-beat packets with m_ready=1 -> packet m_id sequence is 0,1,2,3,0,1; each packet is 2 m_valid beats followed by a 1-cycle gap.
- Backpressure: requester 2 sends 3 beats 0xA,0xB,0xC(last) while m_ready toggles 1,0,0,1,1 -> m_data sequence is exactly A,B,C with no loss or duplication; m_data is held while m_ready=0; m_id=2 on every beat.
- Masking: req_mask=4'b1010 with all s_valid=1 -> grants alternate 1,3,1. Clearing req_mask[1] mid-packet lets that packet finish before requester 1 is excluded.
- Wrap and single-beat: rr_ptr=3 with only requester 0 valid, sending single-beat packets -> consecutive grants to 0, each on m_last=1, one packet every 2 cycles.
- Reset mid-packet: assert rst on the second of 4 beats from requester 1 -> next cycle m_valid=0 and s_ready=0; the next grant after reset goes to requester 0 when all requesters are valid.
